himax_strobe_sched: RTL and testbench

Frame-level scheduler for the Himax IR LED strobe path. Tracks frame boundaries from the sensor vsync, alternates lit and dark frames, and drives the strobe generator's per-frame request and search-mode select from hand-detection results. Runs a search/acquire/track state machine so the LED uses the short search pulse until a hand is locked, then the full pulse. It sits between the CNN result interface and the LED strobe generator, in the same clock domain.

---
 rtl/himax_strobe_sched.sv | 197 +++++++++++++++++++
 tb/tb_himax_strobe_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/himax_strobe_sched.sv
// ============================================================================
// Module      : himax_strobe_sched
// Description : Frame-level IR LED strobe scheduler. It tracks vsync frame
//               boundaries, alternates lit and dark frames, and runs a
//               search/acquire/track FSM that is driven by hand-detection
//               results. The optional vsync watchdog is built only when the
//               macro STROBE_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module himax_strobe_sched #(
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned LOST_FRAMES = 8,
    parameter logic [23:0] WDOG_CYCLES = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_vs,
    input  logic        i_enable,
    input  logic        i_det_valid,
    input  logic        i_det_hit,
    output logic        o_strobe_req,
    output logic        o_search,
    output logic        o_frame_lit,
    output logic [1:0]  o_state,
    output logic [15:0] o_frame_cnt,
    output logic        o_wdog
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_TRACK   = 2'd3
    } state_t;

    localparam logic [3:0] c_lock_frames = 4'(LOCK_FRAMES);
    localparam logic [3:0] c_lost_frames = 4'(LOST_FRAMES);

    state_t      r_state;
    logic [2:0]  r_vs_sync;
    logic        r_phase;
    logic [3:0]  r_hit_cnt;
    logic [3:0]  r_miss_cnt;
    logic        r_strobe_req;
    logic        r_frame_lit;
    logic        r_search;
    logic [15:0] r_frame_cnt;

    logic        w_fe;
    logic        w_wdog_fire;
    logic [3:0]  w_hit_inc;
    logic [3:0]  w_miss_inc;

    // The frame boundary is the vsync falling edge: stage2 is low and stage3 is still high.
    assign w_fe       = ~r_vs_sync[1] & r_vs_sync[2];
    assign w_hit_inc  = r_hit_cnt + 4'd1;
    assign w_miss_inc = r_miss_cnt + 4'd1;

`ifdef STROBE_WATCHDOG_EN
    logic [23:0] r_wdog_cnt;
    logic        r_wdog;

    // An fe takes priority, so the frame that ends a stall resumes normally.
    assign w_wdog_fire = (r_wdog_cnt == WDOG_CYCLES) && !w_fe && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog_cnt <= 24'd0;
            r_wdog     <= 1'b0;
        end else begin
            if (w_fe)
                r_wdog_cnt <= 24'd0;
            else if (r_wdog_cnt != WDOG_CYCLES)
                r_wdog_cnt <= r_wdog_cnt + 24'd1;

            if (w_fe)
                r_wdog <= 1'b0;
            else if (w_wdog_fire)
                r_wdog <= 1'b1;
        end
    end

    assign o_wdog = r_wdog;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_CYCLES;
    assign w_wdog_fire   = 1'b0;
    assign o_wdog        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_sync    <= 3'b000;
            r_state      <= ST_IDLE;
            r_phase      <= 1'b0;
            r_hit_cnt    <= 4'd0;
            r_miss_cnt   <= 4'd0;
            r_strobe_req <= 1'b0;
            r_frame_lit  <= 1'b0;
            r_search     <= 1'b1;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_vs_sync <= {r_vs_sync[1:0], i_vs};

            if (w_fe)
                r_frame_cnt <= r_frame_cnt + 16'd1;

            if (!i_enable) begin
                r_state      <= ST_IDLE;
                r_phase      <= 1'b0;
                r_hit_cnt    <= 4'd0;
                r_miss_cnt   <= 4'd0;
                r_strobe_req <= 1'b0;
                r_frame_lit  <= 1'b0;
                r_search     <= 1'b1;
            end else if (w_wdog_fire) begin
                // Clearing the phase makes the first frame after the stall a lit frame.
                r_state      <= ST_SEARCH;
                r_phase      <= 1'b0;
                r_hit_cnt    <= 4'd0;
                r_miss_cnt   <= 4'd0;
                r_strobe_req <= 1'b0;
                r_frame_lit  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_fe) begin
                            r_state    <= ST_SEARCH;
                            r_phase    <= 1'b0;
                            r_hit_cnt  <= 4'd0;
                            r_miss_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        // Outputs latch from the pre-update state, even when a result arrives on the same cycle.
                        if (w_fe) begin
                            r_phase      <= ~r_phase;
                            r_strobe_req <= ~r_phase;
                            r_frame_lit  <= ~r_phase;
                            r_search     <= (r_state == ST_SEARCH) || (r_state == ST_ACQUIRE);
                        end
                        if (i_det_valid) begin
                            case (r_state)
                                ST_SEARCH: begin
                                    if (i_det_hit) begin
                                        r_hit_cnt <= 4'd1;
                                        if (c_lock_frames == 4'd1) begin
                                            r_state    <= ST_TRACK;
                                            r_miss_cnt <= 4'd0;
                                        end else begin
                                            r_state <= ST_ACQUIRE;
                                        end
                                    end
                                end
                                ST_ACQUIRE: begin
                                    if (i_det_hit) begin
                                        r_hit_cnt <= w_hit_inc;
                                        if (w_hit_inc == c_lock_frames) begin
                                            r_state    <= ST_TRACK;
                                            r_miss_cnt <= 4'd0;
                                        end
                                    end else begin
                                        r_hit_cnt <= 4'd0;
                                        r_state   <= ST_SEARCH;
                                    end
                                end
                                ST_TRACK: begin
                                    if (i_det_hit) begin
                                        r_miss_cnt <= 4'd0;
                                    end else if (w_miss_inc == c_lost_frames) begin
                                        r_state    <= ST_SEARCH;
                                        r_hit_cnt  <= 4'd0;
                                        r_miss_cnt <= 4'd0;
                                    end else begin
                                        r_miss_cnt <= w_miss_inc;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign o_strobe_req = r_strobe_req;
    assign o_frame_lit  = r_frame_lit;
    assign o_search     = r_search;
    assign o_state      = r_state;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_himax_strobe_sched.sv
// ============================================================================
// Module      : tb_himax_strobe_sched
// Description : Scoreboard bench for himax_strobe_sched with directed frames
//               and detection sequences. The watchdog section is built only
//               when STROBE_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_himax_strobe_sched;

    logic        clk;
    logic        reset;
    logic        i_vs;
    logic        i_enable;
    logic        i_det_valid;
    logic        i_det_hit;
    logic        o_strobe_req;
    logic        o_search;
    logic        o_frame_lit;
    logic [1:0]  o_state;
    logic [15:0] o_frame_cnt;
    logic        o_wdog;

    himax_strobe_sched #(
        .LOCK_FRAMES (4),
        .LOST_FRAMES (8),
        .WDOG_CYCLES (24'd1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_vs         (i_vs),
        .i_enable     (i_enable),
        .i_det_valid  (i_det_valid),
        .i_det_hit    (i_det_hit),
        .o_strobe_req (o_strobe_req),
        .o_search     (o_search),
        .o_frame_lit  (o_frame_lit),
        .o_state      (o_state),
        .o_frame_cnt  (o_frame_cnt),
        .o_wdog       (o_wdog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SEL_STATE, SEL_STROBE, SEL_LIT, SEL_SEARCH, SEL_FCNT, SEL_WDOG} sel_t;
    typedef struct {
        sel_t        sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_fcnt = 0;

    function automatic logic [15:0] dut_val(sel_t s);
        case (s)
            SEL_STATE:  return {14'd0, o_state};
            SEL_STROBE: return {15'd0, o_strobe_req};
            SEL_LIT:    return {15'd0, o_frame_lit};
            SEL_SEARCH: return {15'd0, o_search};
            SEL_FCNT:   return o_frame_cnt;
            default:    return {15'd0, o_wdog};
        endcase
    endfunction

    // Monitor: compares queued expectations at the falling edge, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [15:0] got;
                e   = sb_q.pop_front();
                got = dut_val(e.sel);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h at %0t", e.name, got, e.val, $time);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic push(sel_t s, logic [15:0] v, string name);
        exp_t e;
        e.sel  = s;
        e.val  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: vsync high, then fall; outputs are settled 4 cycles after the fall.
    task automatic frame();
        i_vs = 1'b1;
        tick(4);
        i_vs = 1'b0;
        tick(4);
        exp_fcnt++;
    endtask

    task automatic det(logic hit, logic [1:0] exp_state, string name);
        i_det_valid = 1'b1;
        i_det_hit   = hit;
        tick(1);
        i_det_valid = 1'b0;
        i_det_hit   = 1'b0;
        push(SEL_STATE, {14'd0, exp_state}, name);
    endtask

    task automatic expect_out(logic [1:0] st, logic strobe, logic search, string name);
        push(SEL_STATE,  {14'd0, st},     {name, "_state"});
        push(SEL_STROBE, {15'd0, strobe}, {name, "_strobe"});
        push(SEL_LIT,    {15'd0, strobe}, {name, "_lit"});
        push(SEL_SEARCH, {15'd0, search}, {name, "_search"});
        push(SEL_FCNT,   16'(exp_fcnt),   {name, "_fcnt"});
    endtask

    initial begin
        logic [5:0] lit_pat;
        lit_pat     = 6'b101010;
        reset       = 1'b1;
        i_vs        = 1'b1;
        i_enable    = 1'b0;
        i_det_valid = 1'b0;
        i_det_hit   = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        expect_out(2'd0, 1'b0, 1'b1, "reset");
        push(SEL_WDOG, 16'd0, "reset_wdog");

        // Disabled: only the frame counter moves.
        for (int i = 0; i < 3; i++) begin
            frame();
            expect_out(2'd0, 1'b0, 1'b1, "idle_frame");
        end

        // Enable: first fe leaves IDLE, then six alternating frames, starting lit.
        i_enable = 1'b1;
        frame();
        expect_out(2'd1, 1'b0, 1'b1, "enter_search");
        for (int i = 0; i < 6; i++) begin
            frame();
            expect_out(2'd1, lit_pat[5-i], 1'b1, "search_frame");
        end

        // Four hits lock; o_search stays set until the next fe.
        det(1'b1, 2'd2, "lock_hit1");
        det(1'b1, 2'd2, "lock_hit2");
        det(1'b1, 2'd2, "lock_hit3");
        det(1'b1, 2'd3, "lock_hit4");
        push(SEL_SEARCH, 16'd1, "search_before_fe");
        frame();
        expect_out(2'd3, 1'b1, 1'b0, "track_frame");

        // Loss: 7 misses, a hit resets the count, then 8 misses return to SEARCH.
        for (int i = 0; i < 7; i++) det(1'b0, 2'd3, "track_miss7");
        det(1'b1, 2'd3, "track_hit");
        for (int i = 0; i < 7; i++) det(1'b0, 2'd3, "track_miss_a");
        det(1'b0, 2'd1, "track_lost");

        // Three hits, one miss aborts acquisition, then four hits relock.
        for (int i = 0; i < 3; i++) det(1'b1, 2'd2, "acq_hit");
        det(1'b0, 2'd1, "acq_miss");
        for (int i = 0; i < 3; i++) det(1'b1, 2'd2, "reacq_hit");
        det(1'b1, 2'd3, "reacq_lock");

        // Disable on the same cycle as a detection and fe.
        i_vs = 1'b1;
        tick(4);
        i_vs = 1'b0;
        tick(2);
        i_enable    = 1'b0;
        i_det_valid = 1'b1;
        i_det_hit   = 1'b0;
        tick(1);
        i_det_valid = 1'b0;
        exp_fcnt++;
        expect_out(2'd0, 1'b0, 1'b1, "disable");
        tick(2);

        // Re-enable: the fe leaves IDLE and the next frame is lit.
        i_enable = 1'b1;
        frame();
        expect_out(2'd1, 1'b0, 1'b1, "reenable");
        frame();
        expect_out(2'd1, 1'b1, 1'b1, "reenable_lit");

`ifdef STROBE_WATCHDOG_EN
        for (int i = 0; i < 3; i++) det(1'b1, 2'd2, "wd_hit");
        det(1'b1, 2'd3, "wd_lock");
        tick(1010);
        push(SEL_WDOG,   16'd1, "wdog_set");
        push(SEL_STROBE, 16'd0, "wdog_strobe");
        push(SEL_STATE,  16'd1, "wdog_state");
        frame();
        push(SEL_WDOG,   16'd0, "wdog_clear");
        push(SEL_STROBE, 16'd1, "wdog_resume");
`else
        push(SEL_WDOG, 16'd0, "wdog_tied");
`endif

        tick(3);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
